// File: rtl/core_op_sequencer_pkg.sv
// Shared definitions for the crypto-core command sequencer: FSM states, response
// status codes and the idle control word.
package core_op_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      StOk      = 2'b00,
      StTimeout = 2'b01,
      StIllegal = 2'b10
   } rsp_status_e;

   localparam int unsigned CtrlIdle = 0;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return ($clog2(cycles) > 0) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/core_op_sequencer_timeout_cnt.sv
// Saturating watchdog counter for the WAIT phase; expired flags the last allowed
// cycle (count == TIMEOUT_CYCLES-1).
module core_op_sequencer_timeout_cnt
   import core_op_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] count_q, count_d;

   assign expired = (count_q == CntLast);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/core_op_sequencer.sv
// Command stage in front of a crypto core: accepts one command, holds it on the core
// inputs until end_op or watchdog expiry, then presents a result and status word.
module core_op_sequencer
   import core_op_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned ADDR_W         = 64,
   parameter int unsigned CTRL_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              s_cmd_valid,
   output logic              s_cmd_ready,
   input  logic [DATA_W-1:0] s_cmd_data,
   input  logic [ADDR_W-1:0] s_cmd_add,
   input  logic [CTRL_W-1:0] s_cmd_control,
   output logic              m_rsp_valid,
   input  logic              m_rsp_ready,
   output logic [DATA_W-1:0] m_rsp_data,
   output logic [1:0]        m_rsp_status,
   output logic [DATA_W-1:0] o_core_data_in,
   output logic [ADDR_W-1:0] o_core_add,
   output logic [CTRL_W-1:0] o_core_control,
   input  logic [DATA_W-1:0] i_core_data_out,
   input  logic              i_core_end_op,
   output logic              o_busy
);

   seq_state_e  state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] add_q, add_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   rsp_status_e rsp_status_q, rsp_status_d;
   logic        cnt_clear, cnt_en, cnt_expired;

   core_op_sequencer_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .expired(cnt_expired)
   );

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      add_d        = add_q;
      ctrl_d       = ctrl_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (s_cmd_valid) begin
               data_d = s_cmd_data;
               add_d  = s_cmd_add;
               ctrl_d = s_cmd_control;
               if (s_cmd_control == CTRL_W'(CtrlIdle)) begin
                  rsp_data_d   = '0;
                  rsp_status_d = StIllegal;
                  state_d      = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            cnt_clear = 1'b1;
            state_d   = StWait;
         end
         StWait: begin
            // end_op takes priority over a watchdog expiring in the same cycle
            if (i_core_end_op) begin
               rsp_data_d   = i_core_data_out;
               rsp_status_d = StOk;
               state_d      = StResp;
            end else if (cnt_expired) begin
               rsp_data_d   = '0;
               rsp_status_d = StTimeout;
               state_d      = StResp;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StResp: begin
            if (m_rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         data_q       <= '0;
         add_q        <= '0;
         ctrl_q       <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= StOk;
      end else begin
         data_q       <= data_d;
         add_q        <= add_d;
         ctrl_q       <= ctrl_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
      end
   end

   // Control is gated by state so reset or leaving WAIT idles the core at once.
   assign o_core_control = ((state_q == StIssue) || (state_q == StWait)) ? ctrl_q
                                                                         : CTRL_W'(CtrlIdle);
   assign o_core_data_in = data_q;
   assign o_core_add     = add_q;
   assign s_cmd_ready    = (state_q == StIdle);
   assign m_rsp_valid    = (state_q == StResp);
   assign m_rsp_data     = rsp_data_q;
   assign m_rsp_status   = rsp_status_q;
   assign o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_core_op_sequencer.sv
// Self-checking bench for core_op_sequencer: scenario tasks plus randomized commands
// checked against a latency/result reference model.
module tb_core_op_sequencer;

   localparam int TO = 8;

   logic        clk;
   logic        rst_n;
   logic        s_cmd_valid;
   logic        s_cmd_ready;
   logic [63:0] s_cmd_data;
   logic [63:0] s_cmd_add;
   logic [31:0] s_cmd_control;
   logic        m_rsp_valid;
   logic        m_rsp_ready;
   logic [63:0] m_rsp_data;
   logic [1:0]  m_rsp_status;
   logic [63:0] o_core_data_in;
   logic [63:0] o_core_add;
   logic [31:0] o_core_control;
   logic [63:0] core_data_out;
   logic        core_end_op;
   logic        o_busy;

   int checks = 0;
   int errors = 0;

   // Core stub: end_op rises once control has been non-zero for core_lat cycles
   logic end_op_always;
   int   core_lat;
   int   active_cnt;
   int   ctrl_nz_cnt;

   core_op_sequencer #(
      .DATA_W(64),
      .ADDR_W(64),
      .CTRL_W(32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .s_cmd_valid    (s_cmd_valid),
      .s_cmd_ready    (s_cmd_ready),
      .s_cmd_data     (s_cmd_data),
      .s_cmd_add      (s_cmd_add),
      .s_cmd_control  (s_cmd_control),
      .m_rsp_valid    (m_rsp_valid),
      .m_rsp_ready    (m_rsp_ready),
      .m_rsp_data     (m_rsp_data),
      .m_rsp_status   (m_rsp_status),
      .o_core_data_in (o_core_data_in),
      .o_core_add     (o_core_add),
      .o_core_control (o_core_control),
      .i_core_data_out(core_data_out),
      .i_core_end_op  (core_end_op),
      .o_busy         (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) active_cnt <= 0;
      else if (o_core_control != '0) active_cnt <= active_cnt + 1;
      else active_cnt <= 0;
   end

   initial ctrl_nz_cnt = 0;
   always @(negedge clk) if (o_core_control != '0) ctrl_nz_cnt = ctrl_nz_cnt + 1;

   assign core_end_op = end_op_always | ((o_core_control != '0) && (active_cnt >= core_lat));

   // Reference: first WAIT cycle seeing end_op is max(lat,1); response cycle counted
   // from the cycle after the accepting edge (1 = ISSUE cycle).
   function automatic void ref_rsp(input logic [31:0] c, input int lat_cfg, input bit done,
                                   input logic [63:0] core_d, output int e_lat,
                                   output logic [63:0] e_data, output logic [1:0] e_st);
      int k;
      if (c == 32'd0) begin
         e_lat = 1; e_data = '0; e_st = 2'b10;
      end else begin
         k = (done || lat_cfg < 1) ? 1 : lat_cfg;
         if (k <= TO) begin
            e_lat = 2 + k; e_data = core_d; e_st = 2'b00;
         end else begin
            e_lat = 2 + TO; e_data = '0; e_st = 2'b01;
         end
      end
   endfunction

   task automatic accept_cmd(input logic [63:0] d, input logic [63:0] a, input logic [31:0] c,
                             output bit ok);
      s_cmd_data = d; s_cmd_add = a; s_cmd_control = c; s_cmd_valid = 1'b1;
      @(negedge clk);
      ok = s_cmd_ready;
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int first, output int lat);
      lat = -1;
      for (int n = first; n < first + 60; n++) begin
         @(negedge clk);
         if (m_rsp_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic finish_rsp();
      m_rsp_ready = 1'b1;
      @(posedge clk); #1;
      m_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (s_cmd_ready !== 1'b1) begin errors++;
         $display("FAIL reset_ready got %b exp 1", s_cmd_ready); end
      checks++; if (m_rsp_valid !== 1'b0) begin errors++;
         $display("FAIL reset_valid got %b exp 0", m_rsp_valid); end
      checks++; if ({m_rsp_data, m_rsp_status} !== 66'd0) begin errors++;
         $display("FAIL reset_rsp got %h/%b exp 0", m_rsp_data, m_rsp_status); end
      checks++; if ({o_core_data_in, o_core_add, o_core_control} !== 160'd0) begin errors++;
         $display("FAIL reset_core got %h %h %h exp 0", o_core_data_in, o_core_add,
                  o_core_control); end
      checks++; if (o_busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy got %b exp 0", o_busy); end
   endtask

   task automatic test_always_done();
      bit ok; int lat, e_lat; logic [63:0] e_d; logic [1:0] e_s; logic [63:0] d;
      end_op_always = 1'b1;
      core_data_out = 64'hFFFF_FFFF_FFFF_FFFF;
      d = {$urandom, $urandom};
      accept_cmd(d, 64'h10, 32'h1, ok);
      wait_rsp(1, lat);
      ref_rsp(32'h1, 0, 1'b1, core_data_out, e_lat, e_d, e_s);
      checks++; if (!ok || lat !== e_lat) begin errors++;
         $display("FAIL done_latency got %0d exp %0d (accept %0b)", lat, e_lat, ok); end
      checks++; if (m_rsp_data !== e_d || m_rsp_status !== e_s) begin errors++;
         $display("FAIL done_rsp got %h/%b exp %h/%b", m_rsp_data, m_rsp_status, e_d, e_s); end
      checks++; if (o_core_add !== 64'h10 || o_core_data_in !== d || o_core_control !== 0) begin
         errors++; $display("FAIL done_core_hold got %h %h %h exp %h %h 0", o_core_add,
                            o_core_data_in, o_core_control, 64'h10, d); end
      finish_rsp();
      end_op_always = 1'b0;
   endtask

   task automatic test_timeout(input int lat_cfg, input string tag);
      bit ok; int lat, e_lat; logic [63:0] e_d; logic [1:0] e_s; logic [31:0] c;
      core_lat = lat_cfg;
      core_data_out = {$urandom, $urandom};
      c = $urandom | 32'h1;
      accept_cmd({$urandom, $urandom}, {$urandom, $urandom}, c, ok);
      @(negedge clk);
      checks++; if (o_core_control !== c || o_busy !== 1'b1 || s_cmd_ready !== 1'b0) begin
         errors++; $display("FAIL %s_issue got ctrl %h busy %b rdy %b exp %h 1 0", tag,
                            o_core_control, o_busy, s_cmd_ready, c); end
      wait_rsp(2, lat);
      ref_rsp(c, lat_cfg, 1'b0, core_data_out, e_lat, e_d, e_s);
      checks++; if (!ok || lat !== e_lat) begin errors++;
         $display("FAIL %s_latency got %0d exp %0d", tag, lat, e_lat); end
      checks++; if (m_rsp_data !== e_d || m_rsp_status !== e_s) begin errors++;
         $display("FAIL %s_rsp got %h/%b exp %h/%b", tag, m_rsp_data, m_rsp_status, e_d, e_s); end
      checks++; if (o_core_control !== 32'd0) begin errors++;
         $display("FAIL %s_resp_ctrl got %h exp 0", tag, o_core_control); end
      finish_rsp();
   endtask

   task automatic test_illegal();
      bit ok; int lat, nz0;
      nz0 = ctrl_nz_cnt;
      accept_cmd({$urandom, $urandom}, {$urandom, $urandom}, 32'd0, ok);
      wait_rsp(1, lat);
      checks++; if (!ok || lat !== 1) begin errors++;
         $display("FAIL illegal_latency got %0d exp 1", lat); end
      checks++; if (m_rsp_status !== 2'b10 || m_rsp_data !== 64'd0) begin errors++;
         $display("FAIL illegal_rsp got %h/%b exp 0/10", m_rsp_data, m_rsp_status); end
      finish_rsp();
      checks++; if (ctrl_nz_cnt !== nz0) begin errors++;
         $display("FAIL illegal_ctrl_driven got %0d exp 0", ctrl_nz_cnt - nz0); end
   endtask

   task automatic test_backpressure();
      bit ok; int lat, e_lat; logic [63:0] e_d; logic [1:0] e_s; logic [31:0] c2;
      core_lat = 2;
      core_data_out = {$urandom, $urandom};
      accept_cmd({$urandom, $urandom}, {$urandom, $urandom}, 32'h5, ok);
      wait_rsp(1, lat);
      ref_rsp(32'h5, 2, 1'b0, core_data_out, e_lat, e_d, e_s);
      checks++; if (!ok || lat !== e_lat) begin errors++;
         $display("FAIL bp_latency got %0d exp %0d", lat, e_lat); end
      c2 = $urandom | 32'h100;
      s_cmd_data = {$urandom, $urandom}; s_cmd_add = {$urandom, $urandom};
      s_cmd_control = c2; s_cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (m_rsp_valid !== 1'b1 || m_rsp_data !== e_d || m_rsp_status !== e_s ||
             s_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d] got v%b %h/%b rdy %b exp v1 %h/%b rdy 0", i,
                               m_rsp_valid, m_rsp_data, m_rsp_status, s_cmd_ready, e_d, e_s);
         end
      end
      core_data_out = {$urandom, $urandom};
      finish_rsp();
      @(negedge clk);
      checks++; if (s_cmd_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin errors++;
         $display("FAIL bp_next_ready got rdy %b v %b exp 1 0", s_cmd_ready, m_rsp_valid); end
      @(posedge clk); #1;
      s_cmd_valid = 1'b0;
      wait_rsp(1, lat);
      ref_rsp(c2, 2, 1'b0, core_data_out, e_lat, e_d, e_s);
      checks++; if (lat !== e_lat || m_rsp_data !== e_d || m_rsp_status !== e_s) begin
         errors++; $display("FAIL bp_second got %0d %h/%b exp %0d %h/%b", lat, m_rsp_data,
                            m_rsp_status, e_lat, e_d, e_s); end
      finish_rsp();
   endtask

   task automatic test_reset_in_wait();
      bit ok; int lat, e_lat, vcount; logic [63:0] e_d; logic [1:0] e_s;
      core_lat = 1000;
      accept_cmd({$urandom, $urandom}, {$urandom, $urandom}, 32'h7, ok);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (s_cmd_ready !== 1'b1 || o_busy !== 1'b0 || m_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rst_wait_ctl got rdy %b busy %b v %b exp 1 0 0",
                            s_cmd_ready, o_busy, m_rsp_valid); end
      checks++; if ({o_core_data_in, o_core_add, o_core_control, m_rsp_data} !== 224'd0) begin
         errors++; $display("FAIL rst_wait_data got %h %h %h %h exp 0", o_core_data_in,
                            o_core_add, o_core_control, m_rsp_data); end
      @(posedge clk); #2 rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_rsp_valid) vcount++;
      end
      checks++; if (vcount !== 0) begin errors++;
         $display("FAIL rst_no_rsp got %0d valid cycles exp 0", vcount); end
      @(posedge clk); #1;
      core_lat = 3;
      core_data_out = {$urandom, $urandom};
      accept_cmd({$urandom, $urandom}, {$urandom, $urandom}, 32'h9, ok);
      wait_rsp(1, lat);
      ref_rsp(32'h9, 3, 1'b0, core_data_out, e_lat, e_d, e_s);
      checks++; if (!ok || lat !== e_lat || m_rsp_data !== e_d || m_rsp_status !== e_s) begin
         errors++; $display("FAIL rst_recover got %0d %h/%b exp %0d %h/%b", lat, m_rsp_data,
                            m_rsp_status, e_lat, e_d, e_s); end
      finish_rsp();
   endtask

   task automatic test_random();
      bit ok; int lat, e_lat, lc, hold, nz0; logic [63:0] e_d, d, a; logic [1:0] e_s;
      logic [31:0] c;
      for (int it = 0; it < 20; it++) begin
         c = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         lc = $urandom_range(0, TO + 3);
         d = {$urandom, $urandom}; a = {$urandom, $urandom};
         core_lat = lc;
         core_data_out = {$urandom, $urandom};
         nz0 = ctrl_nz_cnt;
         accept_cmd(d, a, c, ok);
         wait_rsp(1, lat);
         ref_rsp(c, lc, 1'b0, core_data_out, e_lat, e_d, e_s);
         checks++; if (!ok || lat !== e_lat) begin errors++;
            $display("FAIL rand[%0d]_latency got %0d exp %0d", it, lat, e_lat); end
         checks++; if (m_rsp_data !== e_d || m_rsp_status !== e_s) begin errors++;
            $display("FAIL rand[%0d]_rsp got %h/%b exp %h/%b", it, m_rsp_data, m_rsp_status,
                     e_d, e_s); end
         checks++;
         if (o_core_add !== a || (c == 32'd0 && ctrl_nz_cnt !== nz0)) begin errors++;
            $display("FAIL rand[%0d]_core got add %h nz %0d exp %h", it, o_core_add,
                     ctrl_nz_cnt - nz0, a); end
         hold = $urandom_range(0, 3);
         repeat (hold) @(negedge clk);
         finish_rsp();
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      s_cmd_valid = 1'b0; s_cmd_data = '0; s_cmd_add = '0; s_cmd_control = '0;
      m_rsp_ready = 1'b0; core_data_out = '0; end_op_always = 1'b0; core_lat = 1000;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      test_always_done();
      test_timeout(1000, "timeout");
      test_illegal();
      test_backpressure();
      test_reset_in_wait();
      test_timeout(TO, "race");
      test_timeout(TO + 1, "late");
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
